// File: rtl/axi4_decerr_slv_if.sv
// AXI4 slave-side bus bundle for the decode-error slave: request and response
// payloads are packed structs carried as two interface variables.
interface axi4_decerr_slv_if;

    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned STRB_W = 8;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned USER_W = 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
    } axi4_metadata_type;

    typedef struct packed {
        logic              aw_valid;
        axi4_metadata_type aw_bits;
        logic [ID_W-1:0]   aw_id;
        logic [USER_W-1:0] aw_user;
        logic              w_valid;
        logic [DATA_W-1:0] w_data;
        logic              w_last;
        logic [STRB_W-1:0] w_strb;
        logic [USER_W-1:0] w_user;
        logic              b_ready;
        logic              ar_valid;
        axi4_metadata_type ar_bits;
        logic [ID_W-1:0]   ar_id;
        logic [USER_W-1:0] ar_user;
        logic              r_ready;
    } axi4_slave_in_type;

    typedef struct packed {
        logic              aw_ready;
        logic              w_ready;
        logic              b_valid;
        logic [1:0]        b_resp;
        logic [ID_W-1:0]   b_id;
        logic [USER_W-1:0] b_user;
        logic              ar_ready;
        logic              r_valid;
        logic [1:0]        r_resp;
        logic [DATA_W-1:0] r_data;
        logic              r_last;
        logic [ID_W-1:0]   r_id;
        logic [USER_W-1:0] r_user;
    } axi4_slave_out_type;

    axi4_slave_in_type  i_xslvi;
    axi4_slave_out_type o_xslvo;

    modport slave  (input i_xslvi, output o_xslvo);
    modport master (output i_xslvi, input o_xslvo);

endinterface

// File: rtl/axi4_decerr_slv.sv
// Default AXI4 slave for unmapped bus0 addresses: accepts every request and
// answers each B/R beat with a fixed error response and fill data.
// Optional error log (o_err_valid/o_err_addr/o_err_cnt) is built only when
// AXI4_DECERR_SLV_LOG_EN is defined; otherwise those outputs are tied to 0.
module axi4_decerr_slv #(
    parameter logic [1:0]  RESP       = 2'b11,
    parameter logic [63:0] RDATA_FILL = 64'hFFFFFFFFFFFFFFFF
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    axi4_decerr_slv_if.slave        io_xslv,
    output logic                    o_err_valid,
    output logic [47:0]             o_err_addr,
    output logic [15:0]             o_err_cnt
);

    localparam int unsigned ADDR_W = 48;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ID_W   = 5;
    localparam int unsigned USER_W = 1;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned ECNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_WRESP = 2'd2,
        ST_RDATA = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt,  w_cnt_nxt;
    logic [CNT_W-1:0]    r_len,  w_len_nxt;
    logic [ID_W-1:0]     r_id,   w_id_nxt;
    logic [USER_W-1:0]   r_user, w_user_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic                w_done;

    // Registered response-channel outputs
    logic                r_a_ready,  w_a_ready_nxt;
    logic                r_w_ready,  w_w_ready_nxt;
    logic                r_b_valid,  w_b_valid_nxt;
    logic [1:0]          r_b_resp,   w_b_resp_nxt;
    logic [ID_W-1:0]     r_b_id,     w_b_id_nxt;
    logic                r_r_valid,  w_r_valid_nxt;
    logic [1:0]          r_r_resp,   w_r_resp_nxt;
    logic [DATA_W-1:0]   r_r_data,   w_r_data_nxt;
    logic                r_r_last,   w_r_last_nxt;
    logic [ID_W-1:0]     r_r_id,     w_r_id_nxt;

    logic                w_ar_hs;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_r_hs;

    assign w_ar_hs = io_xslv.i_xslvi.ar_valid && r_a_ready;
    assign w_aw_hs = io_xslv.i_xslvi.aw_valid && r_a_ready;
    assign w_w_hs  = io_xslv.i_xslvi.w_valid  && r_w_ready;
    assign w_b_hs  = io_xslv.i_xslvi.b_ready  && r_b_valid;
    assign w_r_hs  = io_xslv.i_xslvi.r_ready  && r_r_valid;

    // Next-state, request latching and next registered outputs
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_id_nxt    = r_id;
        w_user_nxt  = r_user;
        w_addr_nxt  = r_addr;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // Reads win a same-cycle tie; a pending AW waits for IDLE again
                if (w_ar_hs) begin
                    w_id_nxt    = io_xslv.i_xslvi.ar_id;
                    w_user_nxt  = io_xslv.i_xslvi.ar_user;
                    w_addr_nxt  = io_xslv.i_xslvi.ar_bits.addr;
                    w_len_nxt   = io_xslv.i_xslvi.ar_bits.len;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_RDATA;
                end else if (w_aw_hs) begin
                    w_id_nxt    = io_xslv.i_xslvi.aw_id;
                    w_user_nxt  = io_xslv.i_xslvi.aw_user;
                    w_addr_nxt  = io_xslv.i_xslvi.aw_bits.addr;
                    w_state_nxt = ST_WDATA;
                end
            end
            ST_WDATA: begin
                // AW len is ignored; only w_last closes the burst
                if (w_w_hs && io_xslv.i_xslvi.w_last) begin
                    w_state_nxt = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (w_b_hs) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RDATA: begin
                if (w_r_hs) begin
                    if (r_r_last) begin
                        w_done      = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt = CNT_W'(r_cnt + CNT_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_a_ready_nxt = (w_state_nxt == ST_IDLE);
        w_w_ready_nxt = (w_state_nxt == ST_WDATA);
        w_b_valid_nxt = (w_state_nxt == ST_WRESP);
        w_b_resp_nxt  = w_b_valid_nxt ? RESP : 2'b00;
        w_b_id_nxt    = w_b_valid_nxt ? w_id_nxt : '0;
        w_r_valid_nxt = (w_state_nxt == ST_RDATA);
        w_r_resp_nxt  = w_r_valid_nxt ? RESP : 2'b00;
        w_r_data_nxt  = w_r_valid_nxt ? RDATA_FILL : '0;
        w_r_last_nxt  = w_r_valid_nxt && (w_cnt_nxt == w_len_nxt);
        w_r_id_nxt    = w_r_valid_nxt ? w_id_nxt : '0;
    end

    // State, latched request and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_id      <= '0;
            r_user    <= '0;
            r_addr    <= '0;
            r_a_ready <= 1'b0;
            r_w_ready <= 1'b0;
            r_b_valid <= 1'b0;
            r_b_resp  <= 2'b00;
            r_b_id    <= '0;
            r_r_valid <= 1'b0;
            r_r_resp  <= 2'b00;
            r_r_data  <= '0;
            r_r_last  <= 1'b0;
            r_r_id    <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_len     <= w_len_nxt;
            r_id      <= w_id_nxt;
            r_user    <= w_user_nxt;
            r_addr    <= w_addr_nxt;
            r_a_ready <= w_a_ready_nxt;
            r_w_ready <= w_w_ready_nxt;
            r_b_valid <= w_b_valid_nxt;
            r_b_resp  <= w_b_resp_nxt;
            r_b_id    <= w_b_id_nxt;
            r_r_valid <= w_r_valid_nxt;
            r_r_resp  <= w_r_resp_nxt;
            r_r_data  <= w_r_data_nxt;
            r_r_last  <= w_r_last_nxt;
            r_r_id    <= w_r_id_nxt;
        end
    end

    assign io_xslv.o_xslvo = '{
        aw_ready: r_a_ready,
        w_ready:  r_w_ready,
        b_valid:  r_b_valid,
        b_resp:   r_b_resp,
        b_id:     r_b_id,
        b_user:   '0,
        ar_ready: r_a_ready,
        r_valid:  r_r_valid,
        r_resp:   r_r_resp,
        r_data:   r_r_data,
        r_last:   r_r_last,
        r_id:     r_r_id,
        r_user:   '0
    };

`ifdef AXI4_DECERR_SLV_LOG_EN
    logic                r_err_valid;
    logic [ADDR_W-1:0]   r_err_addr;
    logic [ECNT_W-1:0]   r_err_cnt;

    // Error log: pulse, last address and saturating count on final handshake
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_err_valid <= w_done;
            if (w_done) begin
                r_err_addr <= r_addr;
                if (r_err_cnt != {ECNT_W{1'b1}}) begin
                    r_err_cnt <= ECNT_W'(r_err_cnt + ECNT_W'(1));
                end
            end
        end
    end

    assign o_err_valid = r_err_valid;
    assign o_err_addr  = r_err_addr;
    assign o_err_cnt   = r_err_cnt;
`else
    assign o_err_valid = 1'b0;
    assign o_err_addr  = '0;
    assign o_err_cnt   = '0;
`endif

    // Request fields this slave intentionally ignores
    logic w_unused;
    assign w_unused = ^{io_xslv.i_xslvi, r_user, r_addr, w_done};

endmodule

// File: doc/axi4_decerr_slv.md
AXI4_DECERR_SLV -- requirements
Module: axi4_decerr_slv

Interface
REQ-001 The block SHALL have parameter RESP, default 2'b11 (DECERR), the response code returned on every B and R beat.
REQ-002 The block SHALL have parameter RDATA_FILL, default 64'hFFFFFFFFFFFFFFFF, the data value driven on every R beat.
REQ-003 The block SHALL have port i_clk, input, 1 bit: system clock, all state on the rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port i_xslvi, input, axi4_slave_in_type: AXI4 AW/W/B/AR/R requests from the bus0 interconnect for accesses that match no CFG_BUS0_MAP entry.
REQ-006 The block SHALL have port o_xslvo, output, axi4_slave_out_type: AXI4 responses to the interconnect.
REQ-007 The block SHALL have port o_err_valid, output, 1 bit: one-cycle pulse per completed erroneous transaction.
REQ-008 The block SHALL have port o_err_addr, output, 48 bits: address of the last erroneous transaction.
REQ-009 The block SHALL have port o_err_cnt, output, 16 bits: count of erroneous transactions.

Function
REQ-010 The block SHALL implement an FSM with four states: IDLE, WDATA, WRESP and RDATA.
REQ-011 In IDLE, the block SHALL assert aw_ready=1 and ar_ready=1; in all other states both SHALL be 0.
REQ-012 When ar_valid and aw_valid are both high in IDLE, the block SHALL accept AR only; AW stays pending until the block returns to IDLE.
REQ-013 On AR handshake, the block SHALL latch ar_id, ar_user, ar_bits.addr and ar_bits.len, clear the beat counter and move to RDATA.
REQ-014 In RDATA, the block SHALL drive:
- r_valid=1
- r_data=RDATA_FILL
- r_resp=RESP
- r_id = latched ID
- r_last=1 when beat counter == latched len
REQ-015 In RDATA, the beat counter (8 bits) SHALL increment on each r_valid&&r_ready.
REQ-016 The block SHALL go from RDATA to IDLE on r_ready when r_last=1.
REQ-017 The first R beat SHALL be valid in the cycle after the AR handshake; with r_ready held high, beats SHALL be back-to-back (len+1 cycles).
REQ-018 On AW handshake, the block SHALL latch aw_id, aw_user and aw_bits.addr, then move to WDATA.
REQ-019 In WDATA, the block SHALL hold w_ready=1 and discard data and strobes.
REQ-020 The block SHALL go from WDATA to WRESP on w_valid&&w_last; AW len is ignored and w_last alone ends the burst.
REQ-021 In WRESP, the block SHALL drive b_valid=1, b_resp=RESP and b_id = latched ID, and go to IDLE on b_ready.
REQ-022 The block SHALL drive w_ready=0 outside WDATA, b_valid=0 outside WRESP and r_valid=0 outside RDATA.
REQ-023 The block SHALL pulse o_err_valid for one cycle on the final B or R handshake.
REQ-024 The block SHALL update o_err_addr from the latched address on that same handshake.
REQ-025 The block SHALL increment o_err_cnt on that same handshake, saturating at 16'hFFFF (no wrap).
REQ-026 A len=255 read SHALL return exactly 256 beats; the beat counter SHALL NOT wrap before r_last.
REQ-027 All o_xslvo fields not listed above SHALL be driven to 0.

Reset
REQ-028 When i_rst=1, the block SHALL immediately force: state=IDLE, beat counter=0, latched ID/user/address=0, o_err_valid=0, o_err_addr=0, o_err_cnt=0.
REQ-029 While i_rst=1, all o_xslvo valid and ready outputs SHALL be 0; aw_ready and ar_ready SHALL rise in the first cycle after release.
REQ-030 Reset asserted mid-burst SHALL abort the transaction with no further beats and no o_err_valid pulse.

Configuration
REQ-031 With AXI4_DECERR_SLV_LOG_EN defined, o_err_valid, o_err_addr and o_err_cnt SHALL behave per REQ-023..025.
REQ-032 Without AXI4_DECERR_SLV_LOG_EN, those three outputs SHALL be tied to 0, no log registers SHALL exist, and AXI behaviour SHALL be unchanged.

Verification
REQ-033 The bench SHALL cover: AR addr=0x40000000, len=3, id=5, r_ready=1 -> 4 beats on consecutive cycles starting 1 cycle after AR, r_resp=3, r_data=all-ones, r_id=5, r_last only on beat 4; o_err_cnt=1, o_err_addr=0x40000000.
REQ-034 The bench SHALL cover: AW id=2 addr=0x20000, then 2 W beats with a 3-cycle w_valid gap, last beat w_last=1 -> single b_valid, b_resp=3, b_id=2; b_ready held low 5 cycles -> b_valid stays high, no new AW/AR accepted.
REQ-035 The bench SHALL cover: AR and AW valid in the same IDLE cycle -> ar_ready handshake first, read completes, then AW accepted; o_err_cnt=2.
REQ-036 The bench SHALL cover: AR len=255 with r_ready toggling every cycle -> exactly 256 beats, r_last on beat 256 only.
REQ-037 The bench SHALL cover: i_rst pulsed during beat 2 of a len=7 read -> r_valid=0 immediately, no o_err_valid pulse, ar_ready=1 the cycle after release, next read behaves normally.
REQ-038 The bench SHALL cover: build without AXI4_DECERR_SLV_LOG_EN -> REQ-033 AXI traffic identical, o_err_* constantly 0.
